// File: rtl/toeplitz_pkg.sv
// Shared types and sizing helpers for the streaming Toeplitz hash engine.
// Default-parameter sizes are provided for reference; modules derive their own.
package toeplitz_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    function automatic int cnt_w(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

    localparam int BS_DEF = 64;
    localparam int N_DEF  = 256;
    localparam int L_DEF  = 128;
    localparam int WORDS  = N_DEF / BS_DEF;
    localparam int DLEN   = L_DEF + N_DEF - 1;
    localparam int WCNT_W = cnt_w(WORDS);

endpackage

// File: rtl/toeplitz_window_xor.sv
// Partial product of one input word against its BS Toeplitz columns.
// Column for word bit b starts at window bit BS-1-b and spans L bits.
module toeplitz_window_xor #(
    parameter int BS = 64,
    parameter int L  = 128
) (
    input  logic [L+BS-2:0] win_i,
    input  logic [BS-1:0]   data_i,
    output logic [L-1:0]    pp_o
);

    always_comb begin
        pp_o = '0;
        for (int b = 0; b < BS; b++) begin
            if (data_i[b]) pp_o = pp_o ^ win_i[BS-1-b +: L];
        end
    end

endmodule

// File: rtl/toeplitz_hash.sv
// Streaming GF(2) Toeplitz hash: h = T*x mod 2, one BS-bit word per beat.
// S holds the diagonal sequence and shifts left by BS so the active window never moves.
module toeplitz_hash
    import toeplitz_pkg::*;
#(
    parameter int BS = 64,
    parameter int N  = 256,
    parameter int L  = 128
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  rrow0,
    input  logic [L-1:0]  col0,
    input  logic          start,
    input  logic [BS-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [L-1:0]  hash,
    output logic          hash_valid,
    input  logic          hash_ready,
    output logic          busy
);

    localparam int NWORDS = N / BS;
    localparam int SLEN   = L + N - 1;
    localparam int CW     = cnt_w(NWORDS);

    state_e          state_q, state_d;
    logic [SLEN-1:0] s_q, s_d;
    logic [L-1:0]    acc_q, acc_d;
    logic [L-1:0]    hash_q, hash_d;
    logic [CW-1:0]   wcnt_q, wcnt_d;
    logic [SLEN-1:0] seed_s;
    logic [L-1:0]    pp;
    logic            last_beat;
    logic            unused_rrow_msb;

    // d[N-1+i] = col0[i]; d[N-1-j] = rrow0[j-1], i.e. the row seed enters bit-reversed
    assign seed_s[SLEN-1:N-1] = col0;
    for (genvar k = 0; k < N - 1; k++) begin : g_rev
        assign seed_s[k] = rrow0[N-2-k];
    end
    assign unused_rrow_msb = rrow0[N-1];

    toeplitz_window_xor #(.BS(BS), .L(L)) u_win (
        .win_i  (s_q[SLEN-1:N-BS]),
        .data_i (in_data),
        .pp_o   (pp)
    );

    assign last_beat = (wcnt_q == CW'(NWORDS - 1));

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        acc_d   = acc_q;
        hash_d  = hash_q;
        wcnt_d  = wcnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    s_d     = seed_s;
                    acc_d   = '0;
                    wcnt_d  = '0;
                end
            end
            RUN: begin
                if (in_valid) begin
                    acc_d  = acc_q ^ pp;
                    s_d    = s_q << BS;
                    wcnt_d = wcnt_q + CW'(1);
                    if (last_beat) begin
                        state_d = DONE;
                        hash_d  = acc_q ^ pp;
                    end
                end
            end
            DONE: begin
                if (hash_ready) begin
                    // start alongside hash_ready chains straight into the next block
                    if (start) begin
                        state_d = RUN;
                        s_d     = seed_s;
                        acc_d   = '0;
                        wcnt_d  = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            s_q     <= '0;
            acc_q   <= '0;
            hash_q  <= '0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            acc_q   <= acc_d;
            hash_q  <= hash_d;
            wcnt_q  <= wcnt_d;
        end
    end

    assign in_ready   = (state_q == RUN);
    assign hash_valid = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign hash       = hash_q;

endmodule

// File: tb/tb_toeplitz_hash.sv
// Bench for toeplitz_hash: directed small-config vectors/sequences plus
// randomized default-config blocks checked against a matrix-level model.
module tb_toeplitz_hash;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // small instance: BS=4, N=8, L=4
    logic [7:0] s_rrow0;
    logic [3:0] s_col0, s_in_data, s_hash;
    logic       s_start, s_in_valid, s_in_ready, s_hash_valid, s_hash_ready, s_busy;

    // default instance: BS=64, N=256, L=128
    logic [255:0] b_rrow0;
    logic [127:0] b_col0, b_hash;
    logic [63:0]  b_in_data;
    logic         b_start, b_in_valid, b_in_ready, b_hash_valid, b_hash_ready, b_busy;

    toeplitz_hash #(.BS(4), .N(8), .L(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .rrow0(s_rrow0), .col0(s_col0), .start(s_start),
        .in_data(s_in_data), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .hash(s_hash), .hash_valid(s_hash_valid), .hash_ready(s_hash_ready), .busy(s_busy)
    );

    toeplitz_hash #(.BS(64), .N(256), .L(128)) dut_b (
        .clk(clk), .rst_n(rst_n), .rrow0(b_rrow0), .col0(b_col0), .start(b_start),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .hash(b_hash), .hash_valid(b_hash_valid), .hash_ready(b_hash_ready), .busy(b_busy)
    );

    int nvec = 0;
    int nmis = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] want);
        nvec++;
        if (act !== want) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endtask

    // T[i][j] = col0[i-j] on/below the diagonal, rrow0[j-i-1] above it
    function automatic logic [127:0] ref_hash(input logic [127:0] c, input logic [255:0] r,
                                              input logic [255:0] x);
        logic [127:0] h;
        logic         acc, t;
        h = '0;
        for (int i = 0; i < 128; i++) begin
            acc = 1'b0;
            for (int j = 0; j < 256; j++) begin
                t   = (i >= j) ? c[i-j] : r[j-i-1];
                acc = acc ^ (t & x[j]);
            end
            h[i] = acc;
        end
        return h;
    endfunction

    task automatic s_beats(input logic [3:0] w0, input logic [3:0] w1);
        s_in_valid = 1'b1;
        s_in_data  = w0;
        @(negedge clk);
        s_in_data  = w1;
        @(negedge clk);
        s_in_valid = 1'b0;
        s_in_data  = 4'h0;
    endtask

    // start then two beats; leaves the engine in DONE. Seeds are scrambled
    // after the start edge so late sampling would corrupt the digest.
    task automatic s_fill(input logic [3:0] c, input logic [7:0] r,
                          input logic [3:0] w0, input logic [3:0] w1);
        @(negedge clk);
        s_start = 1'b1;
        s_col0  = c;
        s_rrow0 = r;
        @(negedge clk);
        s_start = 1'b0;
        s_col0  = ~c;
        s_rrow0 = ~r;
        s_beats(w0, w1);
    endtask

    task automatic s_release();
        s_hash_ready = 1'b1;
        @(negedge clk);
        s_hash_ready = 1'b0;
    endtask

    typedef struct {
        string      nm;
        logic [3:0] col0;
        logic [7:0] rrow0;
        logic [3:0] w0;
        logic [3:0] w1;
        logic [3:0] want;
    } vec_t;

    vec_t tbl[$];

    initial begin
        logic [127:0] c;
        logic [255:0] r, x;
        int           w, cyc;
        int           pat[4] = '{1, 0, 0, 1};

        s_rrow0 = '0; s_col0 = '0; s_in_data = '0;
        s_start = 0; s_in_valid = 0; s_hash_ready = 0;
        b_rrow0 = '0; b_col0 = '0; b_in_data = '0;
        b_start = 0; b_in_valid = 0; b_hash_ready = 0;

        tbl.push_back('{"seed_basic", 4'h1, 8'h00, 4'h1, 4'h0, 4'h1});
        tbl.push_back('{"lower_tri",  4'hF, 8'h00, 4'h2, 4'h0, 4'hE});
        tbl.push_back('{"x4_zero",    4'hF, 8'h00, 4'h0, 4'h1, 4'h0});
        tbl.push_back('{"row_reach",  4'h0, 8'h40, 4'h0, 4'h8, 4'h1});
        tbl.push_back('{"ones_even",  4'hF, 8'hFF, 4'h3, 4'h0, 4'h0});
        tbl.push_back('{"ones_odd",   4'hF, 8'hFF, 4'h7, 4'h0, 4'hF});
        tbl.push_back('{"ones_w1",    4'hF, 8'hFF, 4'h0, 4'h1, 4'hF});

        repeat (2) @(negedge clk);
        chk("rst_in_ready", s_in_ready, 0);
        chk("rst_hash_valid", s_hash_valid, 0);
        chk("rst_busy", s_busy, 0);
        chk("rst_hash", s_hash, 0);
        chk("rst_b_busy", b_busy, 0);
        chk("rst_b_hash", b_hash, 0);
        rst_n = 1'b1;

        // table vectors; hash_valid must already be high the cycle after the last beat
        foreach (tbl[i]) begin
            s_fill(tbl[i].col0, tbl[i].rrow0, tbl[i].w0, tbl[i].w1);
            chk({tbl[i].nm, "_hv"}, s_hash_valid, 1);
            chk(tbl[i].nm, s_hash, tbl[i].want);
            s_release();
            chk({tbl[i].nm, "_idle"}, s_busy, 0);
        end

        // in_valid gaps inside a block
        @(negedge clk);
        s_start = 1'b1; s_col0 = 4'h0; s_rrow0 = 8'h40;
        @(negedge clk);
        s_start = 1'b0; s_col0 = 4'hF; s_rrow0 = 8'hFF;
        w = 0;
        for (int k = 0; k < 4; k++) begin
            chk("gap_ready", s_in_ready, 1);
            s_in_valid = pat[k][0];
            s_in_data  = (w == 0) ? 4'h0 : 4'h8;
            @(negedge clk);
            if (pat[k] != 0) w++;
        end
        s_in_valid = 1'b0;
        chk("gap_hv", s_hash_valid, 1);
        chk("gap_hash", s_hash, 4'h1);
        s_release();

        // hold off hash_ready with a stray start, then chain a block back-to-back
        s_fill(4'hF, 8'h00, 4'h2, 4'h0);
        for (int k = 0; k < 5; k++) begin
            s_start = (k == 2);
            s_col0  = 4'h1;
            s_rrow0 = 8'h00;
            @(negedge clk);
            chk("bp_hv", s_hash_valid, 1);
            chk("bp_in_ready", s_in_ready, 0);
            chk("bp_hash", s_hash, 4'hE);
        end
        s_start = 1'b1; s_hash_ready = 1'b1; s_col0 = 4'h1; s_rrow0 = 8'h00;
        @(negedge clk);
        s_start = 1'b0; s_hash_ready = 1'b0; s_col0 = 4'hA; s_rrow0 = 8'h5A;
        chk("b2b_run", s_in_ready, 1);
        s_beats(4'h1, 4'h0);
        chk("b2b_hv", s_hash_valid, 1);
        chk("b2b_hash", s_hash, 4'h1);
        s_release();

        // async reset after one beat
        @(negedge clk);
        s_start = 1'b1; s_col0 = 4'hF; s_rrow0 = 8'hFF;
        @(negedge clk);
        s_start = 1'b0; s_in_valid = 1'b1; s_in_data = 4'hF;
        @(negedge clk);
        s_in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("ar_in_ready", s_in_ready, 0);
        chk("ar_hash_valid", s_hash_valid, 0);
        chk("ar_busy", s_busy, 0);
        chk("ar_hash", s_hash, 0);
        @(negedge clk);
        rst_n = 1'b1;
        s_fill(4'h1, 8'h00, 4'h1, 4'h0);
        chk("ar_new_hash", s_hash, 4'h1);
        s_release();
        s_fill(4'hF, 8'h00, 4'h0, 4'h0);
        chk("ar_zero_hash", s_hash, 4'h0);
        s_release();

        // randomized default-size blocks
        for (int it = 0; it < 1000; it++) begin
            for (int k = 0; k < 4; k++) c[k*32 +: 32] = $urandom;
            for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
            for (int k = 0; k < 8; k++) x[k*32 +: 32] = $urandom;
            @(negedge clk);
            b_start = 1'b1; b_col0 = c; b_rrow0 = r;
            @(negedge clk);
            b_start = 1'b0; b_col0 = ~c; b_rrow0 = ~r;
            w = 0; cyc = 0;
            while (w < 4 && cyc < 100) begin
                b_in_valid = ($urandom_range(0, 3) != 0);
                b_in_data  = x[w*64 +: 64];
                @(negedge clk);
                if (b_in_valid) w++;
                cyc++;
            end
            b_in_valid = 1'b0;
            if (w < 4) chk("rnd_feed_timeout", w, 4);
            chk("rnd_hv", b_hash_valid, 1);
            chk("rnd_hash", b_hash, ref_hash(c, r, x));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            b_hash_ready = 1'b1;
            @(negedge clk);
            b_hash_ready = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/toeplitz_hash.md
Name: toeplitz_hash

Overview:
- Streaming GF(2) Toeplitz hash engine for privacy amplification.
- Sits directly downstream of the row/column seed loader; consumes its static rrow0 (reversed first row) and col0 (first column) vectors.
- Hashes one N-bit input block, delivered as BS-bit words, into an L-bit digest h = T·x mod 2. T is the L×N Toeplitz matrix defined by the seeds.

Parameters:
BS, 64, input word width (bits consumed per accepted beat)
N, 256, input block length in bits; N % BS == 0
L, 128, hash output length in bits; L >= 1

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
rrow0  in  N  reversed first row from seed loader; rrow0[j-1] = T[0][j] for j=1..N-1; rrow0[N-1] ignored
col0  in  L  first column; col0[i] = T[i][0]
start  in  1  pulse: latch seeds, clear accumulator, begin block
in_data  in  BS  input word; bit b of word w is x[w*BS+b]
in_valid  in  1  in_data valid
in_ready  out  1  engine accepts a word this cycle
hash  out  L  digest; hash[i] = XOR_j T[i][j]&x[j]
hash_valid  out  1  hash is complete and stable
hash_ready  in  1  downstream consumes hash
busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n low, async): state=IDLE; in_ready=0, hash_valid=0, busy=0, hash=0, word counter=0, shift register S=0.
- Diagonal sequence d[k], k=0..L+N-2: d[N-1+i]=col0[i] for i=0..L-1; d[N-1-j]=rrow0[j-1] for j=1..N-1. Then T[i][j]=d[N-1-j+i].
- S is an (L+N-1)-bit register holding d. Column j = S[N-1-j +: L].
- FSM states: IDLE, RUN, DONE.
- IDLE: when start=1, load S from d, clear acc, clear wcnt, go to RUN next cycle. rrow0/col0 are sampled only at this edge.
- RUN: in_ready=1.
  - On in_valid&&in_ready: acc <= acc ^ XOR_{b=0..BS-1}(in_data[b] ? S[N-1-b +: L] : 0).
  - Same edge: S <= S << BS (zero fill); wcnt++.
  - On the beat with wcnt==N/BS-1: go to DONE.
  - in_valid low stalls with no state change.
- DONE: hash_valid=1, hash=acc held stable, in_ready=0.
  - On hash_ready: go to IDLE.
  - If start=1 in the same cycle as hash_ready: go directly to RUN with fresh seeds, so back-to-back blocks lose no cycle.
- hash is registered; it updates only on the transition into DONE and holds until the next DONE.
- Latency: hash_valid rises the cycle after the last accepted beat. Minimum block time is N/BS+1 cycles.
- start while in RUN, or in DONE without hash_ready: ignored.
- Async reset mid-block: partial block discarded, outputs return to reset values immediately.
- wcnt width is clog2(N/BS) bits, minimum 1. Terminal count compare only, no wrap reliance.
- Arithmetic is pure XOR/AND; no carries.

Decomposition:
- Package toeplitz_pkg: state_e enum {IDLE, RUN, DONE}; localparams WORDS=N/BS, DLEN=L+N-1, WCNT_W.
- One sub-module, toeplitz_window_xor: combinational; inputs S window (L+BS-1 bits) and in_data; output the L-bit partial product XOR.
- The top holds the FSM, S, acc and the handshake.

Test Plan (BS=4, N=8, L=4 unless noted):
1. Seed/basic: col0=4'h1, rrow0=0; start; words 4'h1, 4'h0 -> hash_valid after 3rd cycle from first beat, hash=4'h1.
2. Lower triangle: col0=4'hF, rrow0=0; words 4'h2, 4'h0 -> hash=4'hE. Words 4'h0, 4'h1 (x[4]) -> hash=4'h0.
3. Row reach: col0=0, rrow0=8'h40 (T[0][7]=1); words 4'h0, 4'h8 -> hash=4'h1. Also with in_valid toggling 1,0,0,1 -> same hash; in_ready asserted throughout RUN.
4. Backpressure: hold hash_ready=0 for 5 cycles -> hash_valid stays 1, hash stable, in_ready=0, stray start ignored. hash_ready+start together -> RUN next cycle, second block hashes correctly.
5. Reset mid-block: assert rst_n=0 after 1 beat -> in_ready/hash_valid/busy=0 immediately. A new block after release gives the correct hash, with no residue from the aborted block.
6. Default params, 1000 random seeds and blocks: compare against a bench reference model computing T·x mod 2 bit by bit. Zero mismatches required.
